// File: rtl/wb_hyperram_arbiter.sv
// wb_hyperram_arbiter
// -------------------
// Two-master Wishbone classic arbiter in front of the single slave port of
// wrapped_wb_hyperram. Master 0 is the management SoC bus, master 1 is a
// secondary on-chip requester (test engine / DMA).
//
// Arbitration is round-robin, registered (one cycle from request to slave
// strobe) and locked for the whole bus cycle: a grant is released only when
// the owner drops cyc, and there is always one IDLE cycle between owners.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   m0_* / m1_*                 master-side Wishbone ports (cyc/stb/we/sel/
//                               adr/dat in, ack/dat out)
//   s_*                         slave-side Wishbone port towards the hyperram
//   grant_o                     one-hot current owner, 00 when idle
//   timeout_o                   sticky stall-timeout flag
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   When defined, an access stalled for TIMEOUT_CYCLES strobed cycles is
//   terminated locally with an ack carrying TIMEOUT_DATA, timeout_o is set
//   until reset and the offending master is locked out until it drops cyc.
//   When undefined, timeout_o is tied low and stalls wait forever.

module wb_hyperram_arbiter #(
    parameter int unsigned    AW             = 32,
    parameter int unsigned    DW             = 32,
    parameter int unsigned    TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0]  TIMEOUT_DATA   = DW'(32'hDEAD_BEEF)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic              m0_ack_o,
    output logic [DW-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic              m1_ack_o,
    output logic [DW-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic              s_ack_i,
    input  logic [DW-1:0]     s_dat_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_owner;
    logic       own0;
    logic       own1;
    logic       req0;
    logic       req1;
    logic       mask0;
    logic       mask1;
    logic       to_fire;

    assign own0    = (state == OWN0);
    assign own1    = (state == OWN1);
    assign grant_o = {own1, own0};

    // A master that was timed out keeps its request masked until it drops
    // cyc, so a stuck master cannot immediately re-grab the bus.
    assign req0 = m0_cyc_i & m0_stb_i & ~mask0;
    assign req1 = m1_cyc_i & m1_stb_i & ~mask1;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tcount;
    logic          owner_stb;
    logic          stalled;
    logic          timeout_q;

    assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
    assign stalled   = owner_stb & ~s_ack_i;
    assign to_fire   = stalled & (tcount == CW'(TIMEOUT_CYCLES));
    assign timeout_o = timeout_q;

    // Stall counter: counts strobed cycles without ack while owned; any ack,
    // strobe gap or loss of ownership restarts it. The lock-out masks are
    // set by a timeout and released once the master lets go of cyc.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tcount    <= '0;
            timeout_q <= 1'b0;
            mask0     <= 1'b0;
            mask1     <= 1'b0;
        end else begin
            if (to_fire) begin
                tcount    <= '0;
                timeout_q <= 1'b1;
            end else if (stalled && state_next == state) begin
                tcount <= tcount + 1'b1;
            end else begin
                tcount <= '0;
            end

            if (to_fire && own0)
                mask0 <= 1'b1;
            else if (!m0_cyc_i)
                mask0 <= 1'b0;

            if (to_fire && own1)
                mask1 <= 1'b1;
            else if (!m1_cyc_i)
                mask1 <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^{TIMEOUT_DATA, 32'(TIMEOUT_CYCLES)};
    assign to_fire   = 1'b0;
    assign mask0     = 1'b0;
    assign mask1     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state logic. On a tie in IDLE the master that did not own the bus
    // last wins; ownership ends only when the owner drops cyc (or on a
    // timeout), never by handing straight to the other master.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_next = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: if (!m0_cyc_i || to_fire) state_next = IDLE;
            OWN1: if (!m1_cyc_i || to_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; last_owner starts at 1 so master 0 wins the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == OWN0)
                last_owner <= 1'b0;
            else if (state == IDLE && state_next == OWN1)
                last_owner <= 1'b1;
        end
    end

    // Bus multiplexing. The owner's signals pass straight through; the slave
    // ack is only forwarded while the owner is strobing, so stray acks are
    // dropped. A timeout suppresses the slave strobe and answers locally.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i & ~to_fire;
            s_stb_o  = m0_stb_i & ~to_fire;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = (s_ack_i & m0_stb_i) | to_fire;
            m0_dat_o = to_fire ? TIMEOUT_DATA : s_dat_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i & ~to_fire;
            s_stb_o  = m1_stb_i & ~to_fire;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = (s_ack_i & m1_stb_i) | to_fire;
            m1_dat_o = to_fire ? TIMEOUT_DATA : s_dat_i;
        end
    end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// tb_wb_hyperram_arbiter
// ----------------------
// Directed bench for wb_hyperram_arbiter. The bench plays both masters and
// the hyperram slave. Expected (master, read data) pairs are queued when a
// request is issued and popped when the corresponding ack appears.
// Inputs change on the falling clock edge; outputs are checked 1 ns later.
// The timeout scenario runs only when WB_ARB_TIMEOUT_EN is defined.

module tb_wb_hyperram_arbiter;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    typedef struct {
        int          who;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    wb_hyperram_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    task automatic step();
        @(negedge wb_clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one master's request lines.
    task automatic applyStimulus(int m, logic cyc, logic stb, logic we,
                                 logic [31:0] adr, logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_sel_i = 4'hF; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    // Pop the oldest expected response and check it against the ack lines.
    task automatic checkAck(string tag);
        exp_t e;
        checkOutput({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.who == 0) begin
                checkOutput({tag, "_m0ack"}, 32'(m0_ack_o), 32'd1);
                checkOutput({tag, "_m1ack"}, 32'(m1_ack_o), 32'd0);
                checkOutput({tag, "_m0dat"}, m0_dat_o, e.data);
            end else begin
                checkOutput({tag, "_m1ack"}, 32'(m1_ack_o), 32'd1);
                checkOutput({tag, "_m0ack"}, 32'(m0_ack_o), 32'd0);
                checkOutput({tag, "_m1dat"}, m1_dat_o, e.data);
            end
        end
    endtask

    // Both masters request on the same edge; `first` is the expected winner.
    task automatic serveBoth(string tag, int first);
        int          owner;
        logic [31:0] adr;
        step();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        exp_q.push_back('{who: first,     data: 32'hA000_0000 | (first     == 1 ? 32'h200 : 32'h100)});
        exp_q.push_back('{who: 1 - first, data: 32'hA000_0000 | (first     == 1 ? 32'h100 : 32'h200)});
        settle();
        checkOutput({tag, "_grant_req"}, 32'(grant_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            owner = (k == 0) ? first : 1 - first;
            adr   = (owner == 1) ? 32'h200 : 32'h100;
            step(); settle();
            checkOutput({tag, "_grant"}, 32'(grant_o), (owner == 1) ? 32'd2 : 32'd1);
            checkOutput({tag, "_sadr"}, s_adr_o, adr);
            s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 | adr;
            settle();
            checkAck(tag);
            step();
            s_ack_i = 1'b0;
            applyStimulus(owner, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            settle();
            step(); settle();
            checkOutput({tag, "_gap"}, 32'(grant_o), 32'd0);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        s_ack_i  = 1'b0;
        s_dat_i  = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step(); settle();
        checkOutput("rst_grant",   32'(grant_o),   32'd0);
        checkOutput("rst_scyc",    32'(s_cyc_o),   32'd0);
        checkOutput("rst_sstb",    32'(s_stb_o),   32'd0);
        checkOutput("rst_m0ack",   32'(m0_ack_o),  32'd0);
        checkOutput("rst_m1ack",   32'(m1_ack_o),  32'd0);
        checkOutput("rst_m0dat",   m0_dat_o,       32'd0);
        checkOutput("rst_timeout", 32'(timeout_o), 32'd0);

        // m0 single read with a 3-cycle slave latency
        $display("[TB] m0 single read");
        step();
        wb_rst_i = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        exp_q.push_back('{who: 0, data: 32'h1234_5678});
        settle();
        checkOutput("t1_latency_stb", 32'(s_stb_o), 32'd0);
        checkOutput("t1_latency_gnt", 32'(grant_o), 32'd0);
        step(); settle();
        checkOutput("t1_grant", 32'(grant_o), 32'd1);
        checkOutput("t1_sstb",  32'(s_stb_o), 32'd1);
        checkOutput("t1_scyc",  32'(s_cyc_o), 32'd1);
        checkOutput("t1_sadr",  s_adr_o,      32'h0000_0010);
        checkOutput("t1_swe",   32'(s_we_o),  32'd0);
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            checkOutput("t1_wait_ack", 32'(m0_ack_o), 32'd0);
        end
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        settle();
        checkAck("t1");
        step();
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        checkOutput("t1_hold", 32'(grant_o), 32'd1);
        step(); settle();
        checkOutput("t1_release", 32'(grant_o), 32'd0);
        checkOutput("t1_rel_scyc", 32'(s_cyc_o), 32'd0);

        // simultaneous requests: m0 owned last, so m1 wins, then m0
        $display("[TB] round robin after m0");
        serveBoth("t2a", 1);
        // after reset m0 wins the first tie
        $display("[TB] round robin after reset");
        step(); wb_rst_i = 1'b1;
        step(); wb_rst_i = 1'b0;
        serveBoth("t2b", 0);

        // m1 write while m0 idle
        $display("[TB] m1 write");
        step();
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
        exp_q.push_back('{who: 1, data: 32'h0});
        settle();
        step(); settle();
        checkOutput("t3_grant", 32'(grant_o), 32'd2);
        checkOutput("t3_sadr",  s_adr_o,      32'h40);
        checkOutput("t3_sdat",  s_dat_o,      32'hCAFE_F00D);
        checkOutput("t3_swe",   32'(s_we_o),  32'd1);
        checkOutput("t3_ssel",  32'(s_sel_o), 32'hF);
        checkOutput("t3_noack", 32'(m1_ack_o), 32'd0);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h0;
        settle();
        checkAck("t3");
        step();
        s_ack_i = 1'b0;
        settle();
        checkOutput("t3_ack_drop", 32'(m1_ack_o), 32'd0);
        step();
        m1_stb_i = 1'b0; s_ack_i = 1'b1;
        settle();
        checkOutput("t3_nostb_ack",   32'(m1_ack_o), 32'd0);
        checkOutput("t3_nostb_sstb",  32'(s_stb_o),  32'd0);
        checkOutput("t3_nostb_scyc",  32'(s_cyc_o),  32'd1);
        checkOutput("t3_nostb_grant", 32'(grant_o),  32'd2);
        step();
        s_ack_i = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        step(); settle();
        checkOutput("t3_release", 32'(grant_o), 32'd0);

        // stray slave ack while idle
        $display("[TB] spurious ack in idle");
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hFFFF_FFFF;
        settle();
        checkOutput("t4_m0ack", 32'(m0_ack_o), 32'd0);
        checkOutput("t4_m1ack", 32'(m1_ack_o), 32'd0);
        checkOutput("t4_m0dat", m0_dat_o,      32'd0);
        checkOutput("t4_m1dat", m1_dat_o,      32'd0);
        step(); settle();
        checkOutput("t4_grant", 32'(grant_o), 32'd0);
        s_ack_i = 1'b0;

        // reset while m1 owns with a pending strobe
        $display("[TB] reset during OWN1");
        step();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        settle();
        step(); settle();
        checkOutput("t5_grant_pre", 32'(grant_o), 32'd2);
        step(); wb_rst_i = 1'b1; settle();
        step();
        wb_rst_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
        settle();
        checkOutput("t5_grant", 32'(grant_o),  32'd0);
        checkOutput("t5_scyc",  32'(s_cyc_o),  32'd0);
        checkOutput("t5_m1ack", 32'(m1_ack_o), 32'd0);
        step();
        s_ack_i = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        step(); settle();
        checkOutput("t5_idle", 32'(grant_o), 32'd0);

`ifdef WB_ARB_TIMEOUT_EN
        // slave never acks: timeout answers on the 9th strobed cycle
        $display("[TB] stall timeout");
        step();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        exp_q.push_back('{who: 0, data: 32'hDEAD_BEEF});
        settle();
        for (int i = 0; i < 8; i++) begin
            step(); settle();
            checkOutput("t6_stall_ack", 32'(m0_ack_o), 32'd0);
            checkOutput("t6_stall_stb", 32'(s_stb_o),  32'd1);
        end
        step();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
        settle();
        checkAck("t6");
        checkOutput("t6_fire_stb", 32'(s_stb_o), 32'd0);
        checkOutput("t6_fire_cyc", 32'(s_cyc_o), 32'd0);
        step(); settle();
        checkOutput("t6_grant_idle", 32'(grant_o),   32'd0);
        checkOutput("t6_flag",       32'(timeout_o), 32'd1);
        step(); settle();
        checkOutput("t6_grant_m1", 32'(grant_o), 32'd2);
        exp_q.push_back('{who: 1, data: 32'h0BAD_CAFE});
        s_ack_i = 1'b1; s_dat_i = 32'h0BAD_CAFE;
        settle();
        checkAck("t6_m1");
        step();
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        step(); settle();
        checkOutput("t6_end_grant", 32'(grant_o),   32'd0);
        checkOutput("t6_sticky",    32'(timeout_o), 32'd1);
`else
        checkOutput("timeout_tied", 32'(timeout_o), 32'd0);
`endif

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
